// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit sitting between the datapath and data memory.
// Takes one load/store request at a time over valid/ready, drives the dmem
// a/wd/we/mode pins and consumes dmem's combinational read data. Aligned
// accesses are a single dmem access; misaligned halfword/word accesses are
// broken into sequential byte accesses and reassembled here.
//
// Build option: define DMEM_LSU_MISALIGN_TRAP_EN to reject misaligned legal
// requests with resp_err instead of splitting them (the SPLIT path is then
// left out entirely).
module dmem_lsu #(
    parameter int         ADDR_W  = 32,
    parameter logic [2:0] LB_MODE = 3'b100,
    parameter logic [2:0] SB_MODE = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    output logic [2:0]        mem_mode,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [31:0]       wdata_q;

    logic              req_illegal;
    logic              req_aligned;

`ifndef DMEM_LSU_MISALIGN_TRAP_EN
    logic [1:0]        k;
    logic [1:0]        k_next;
    logic [1:0]        k_last;
    logic [31:0]       asm_q;
    logic [31:0]       asm_next;
    logic [ADDR_W-1:0] split_next_addr;
    logic [7:0]        split_next_byte;
`endif

    // Sign/zero-extend a reassembled misaligned load according to funct3.
    function automatic logic [31:0] extend_split(input logic [2:0] f3,
                                                 input logic [31:0] raw);
        logic [31:0] r;
        case (f3)
            3'b001:  r = {{16{raw[15]}}, raw[15:0]};
            3'b101:  r = {16'b0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Classify the incoming request: funct3 legality and natural alignment.
    always_comb begin
        req_illegal = 1'b0;
        req_aligned = 1'b0;
        if (req_we) begin
            req_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                            req_funct3 == 3'b010);
        end else begin
            req_illegal = (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                           req_funct3 == 3'b111);
        end
        case (req_funct3[1:0])
            2'b00:   req_aligned = 1'b1;
            2'b01:   req_aligned = (req_addr[0] == 1'b0);
            2'b10:   req_aligned = (req_addr[1:0] == 2'b00);
            default: req_aligned = 1'b0;
        endcase
    end

`ifndef DMEM_LSU_MISALIGN_TRAP_EN
    // Split-path helpers: merge the current byte into the assembly register
    // and precompute the address/data for the following byte access.
    always_comb begin
        k_next   = k + 2'd1;
        k_last   = funct3_q[1] ? 2'd3 : 2'd1;
        asm_next = asm_q;
        asm_next[8*k +: 8] = mem_rd[7:0];
        split_next_addr = addr_q + ADDR_W'(k_next);
        split_next_byte = wdata_q[8*k_next +: 8];
    end
`endif

    // Main control FSM; every output is registered so reset clears them at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= 32'h0;
            mem_we     <= 1'b0;
            mem_mode   <= 3'b000;
`ifndef DMEM_LSU_MISALIGN_TRAP_EN
            k          <= 2'd0;
            asm_q      <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        funct3_q  <= req_funct3;
                        we_q      <= req_we;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (req_aligned) begin
                            state    <= ACCESS;
                            mem_a    <= req_addr;
                            mem_mode <= req_funct3;
                            mem_we   <= req_we;
                            mem_wd   <= req_wdata;
                        end else begin
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
`else
                            state    <= SPLIT;
                            k        <= 2'd0;
                            asm_q    <= 32'h0;
                            mem_a    <= req_addr;
                            mem_mode <= req_we ? SB_MODE : LB_MODE;
                            mem_we   <= req_we;
                            mem_wd   <= {24'b0, req_wdata[7:0]};
`endif
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                ACCESS: begin
                    state      <= RESP;
                    mem_a      <= '0;
                    mem_wd     <= 32'h0;
                    mem_we     <= 1'b0;
                    mem_mode   <= 3'b000;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= we_q ? 32'h0 : mem_rd;
                end

`ifndef DMEM_LSU_MISALIGN_TRAP_EN
                SPLIT: begin
                    if (k == k_last) begin
                        state      <= RESP;
                        mem_a      <= '0;
                        mem_wd     <= 32'h0;
                        mem_we     <= 1'b0;
                        mem_mode   <= 3'b000;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? 32'h0 : extend_split(funct3_q, asm_next);
                    end else begin
                        k      <= k_next;
                        asm_q  <= asm_next;
                        mem_a  <= split_next_addr;
                        mem_wd <= {24'b0, split_next_byte};
                    end
                end
`endif

                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    req_ready  <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    mem_we    <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a small byte-array dmem model.
// The model decodes only mem_a[3:0], so the addresses used below are chosen
// not to alias one another.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    dmem_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_mode   (mem_mode),
        .mem_rd     (mem_rd)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // dmem model storage, 16 little-endian bytes.
    logic [7:0] mem [0:15] = '{default: 8'h00};
    logic [3:0] i0, i1, i2, i3;

    // Byte lane indices with 4-bit wrap.
    always_comb begin
        i0 = mem_a[3:0];
        i1 = 4'(mem_a[3:0] + 4'd1);
        i2 = 4'(mem_a[3:0] + 4'd2);
        i3 = 4'(mem_a[3:0] + 4'd3);
    end

    // Combinational dmem read, RV32-style mode decode.
    always_comb begin
        case (mem_mode)
            3'b000:  mem_rd = {{24{mem[i0][7]}}, mem[i0]};
            3'b001:  mem_rd = {{16{mem[i1][7]}}, mem[i1], mem[i0]};
            3'b010:  mem_rd = {mem[i3], mem[i2], mem[i1], mem[i0]};
            3'b100:  mem_rd = {24'b0, mem[i0]};
            3'b101:  mem_rd = {16'b0, mem[i1], mem[i0]};
            default: mem_rd = 32'h0;
        endcase
    end

    // dmem write port plus logs of every write and every unsigned-byte read.
    int          wcnt = 0;
    int          rcnt = 0;
    logic [31:0] wlogA [0:63];
    logic [31:0] wlogD [0:63];
    logic [2:0]  wlogM [0:63];
    logic [31:0] rlogA [0:63];

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_mode[1:0])
                2'b00: mem[i0] <= mem_wd[7:0];
                2'b01: begin
                    mem[i0] <= mem_wd[7:0];
                    mem[i1] <= mem_wd[15:8];
                end
                2'b10: begin
                    mem[i0] <= mem_wd[7:0];
                    mem[i1] <= mem_wd[15:8];
                    mem[i2] <= mem_wd[23:16];
                    mem[i3] <= mem_wd[31:24];
                end
                default: ;
            endcase
            if (wcnt < 64) begin
                wlogA[wcnt] <= mem_a;
                wlogD[wcnt] <= mem_wd;
                wlogM[wcnt] <= mem_mode;
            end
            wcnt <= wcnt + 1;
        end else if (mem_mode == 3'b100) begin
            if (rcnt < 64) rlogA[rcnt] <= mem_a;
            rcnt <= rcnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one request and wait (bounded) for its response pulse.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output int lat, output logic [31:0] rdata,
                                 output logic err, output logic readyInResp);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) checkOutput("ready_timeout", {31'b0, req_ready}, 32'd1);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        rdata       = resp_rdata;
        err         = resp_err;
        readyInResp = req_ready;
    endtask

    int          lat;
    int          w0;
    int          r0;
    logic [31:0] rdata;
    logic        err;
    logic        rdy;
    logic [31:0] expA [0:3];
    logic [31:0] expD [0:3];

    initial begin
        $display("[TB] dmem_lsu directed test start");
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rst_mem_a", mem_a, 32'd0);
        reset = 1'b1;

        // Aligned word store then load.
        w0 = wcnt;
        applyStimulus(1'b1, 3'b010, 32'd4, 32'hF00AA00F, lat, rdata, err, rdy);
        checkOutput("sw4_lat", 32'(lat), 32'd2);
        checkOutput("sw4_rdata", rdata, 32'h0);
        checkOutput("sw4_err", {31'b0, err}, 32'd0);
        checkOutput("sw4_ready_in_resp", {31'b0, rdy}, 32'd0);
        checkOutput("sw4_we_pulses", 32'(wcnt - w0), 32'd1);
        checkOutput("sw4_mode", {29'b0, wlogM[w0]}, 32'h2);
        checkOutput("sw4_addr", wlogA[w0], 32'd4);
        applyStimulus(1'b0, 3'b010, 32'd4, 32'h0, lat, rdata, err, rdy);
        checkOutput("lw4_lat", 32'(lat), 32'd2);
        checkOutput("lw4_rdata", rdata, 32'hF00AA00F);

`ifndef DMEM_LSU_MISALIGN_TRAP_EN
        // Misaligned word store split into four byte writes.
        w0 = wcnt;
        applyStimulus(1'b1, 3'b010, 32'd5, 32'h11223344, lat, rdata, err, rdy);
        expA = '{32'd5, 32'd6, 32'd7, 32'd8};
        expD = '{32'h44, 32'h33, 32'h22, 32'h11};
        checkOutput("sw5_lat", 32'(lat), 32'd5);
        checkOutput("sw5_we_pulses", 32'(wcnt - w0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("sw5_a%0d", i), wlogA[w0 + i], expA[i]);
            checkOutput($sformatf("sw5_wd%0d", i), wlogD[w0 + i], expD[i]);
            checkOutput($sformatf("sw5_mode%0d", i), {29'b0, wlogM[w0 + i]}, 32'h0);
        end
        applyStimulus(1'b0, 3'b010, 32'd5, 32'h0, lat, rdata, err, rdy);
        checkOutput("lw5_lat", 32'(lat), 32'd5);
        checkOutput("lw5_rdata", rdata, 32'h11223344);

        // Misaligned halfword loads, signed and unsigned.
        applyStimulus(1'b1, 3'b000, 32'd11, 32'h00000080, lat, rdata, err, rdy);
        applyStimulus(1'b1, 3'b000, 32'd12, 32'h000000FF, lat, rdata, err, rdy);
        applyStimulus(1'b0, 3'b001, 32'd11, 32'h0, lat, rdata, err, rdy);
        checkOutput("lh11_lat", 32'(lat), 32'd3);
        checkOutput("lh11_rdata", rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b101, 32'd11, 32'h0, lat, rdata, err, rdy);
        checkOutput("lhu11_rdata", rdata, 32'h0000FF80);

        // Halfword load wrapping past the top of the address space.
        applyStimulus(1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000034, lat, rdata, err, rdy);
        applyStimulus(1'b1, 3'b000, 32'h00000000, 32'h00000012, lat, rdata, err, rdy);
        r0 = rcnt;
        applyStimulus(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, lat, rdata, err, rdy);
        checkOutput("lhwrap_rdata", rdata, 32'h00001234);
        checkOutput("lhwrap_reads", 32'(rcnt - r0), 32'd2);
        checkOutput("lhwrap_a0", rlogA[r0], 32'hFFFFFFFF);
        checkOutput("lhwrap_a1", rlogA[r0 + 1], 32'h00000000);
`endif

        // Illegal funct3 on a load and on a store.
        w0 = wcnt;
        applyStimulus(1'b0, 3'b011, 32'd4, 32'h0, lat, rdata, err, rdy);
        checkOutput("ill_ld_lat", 32'(lat), 32'd1);
        checkOutput("ill_ld_err", {31'b0, err}, 32'd1);
        checkOutput("ill_ld_rdata", rdata, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'd4, 32'hFFFFFFFF, lat, rdata, err, rdy);
        checkOutput("ill_st_err", {31'b0, err}, 32'd1);
        checkOutput("ill_st_rdata", rdata, 32'h0);
        checkOutput("ill_no_we", 32'(wcnt - w0), 32'd0);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        // Misaligned word load is trapped without touching memory.
        w0 = wcnt;
        r0 = rcnt;
        applyStimulus(1'b0, 3'b010, 32'd6, 32'h0, lat, rdata, err, rdy);
        checkOutput("trap_lat", 32'(lat), 32'd1);
        checkOutput("trap_err", {31'b0, err}, 32'd1);
        checkOutput("trap_rdata", rdata, 32'h0);
        checkOutput("trap_no_access", 32'((wcnt - w0) + (rcnt - r0)), 32'd0);
`else
        // Reset asserted in the middle of a split store.
        w0 = wcnt;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd5; req_wdata = 32'hAABBCCDD;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstmid_we_before", {31'b0, mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rstmid_we_drop", {31'b0, mem_we}, 32'd0);
        checkOutput("rstmid_ready_low", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        checkOutput("rstmid_ready_held", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rstmid_ready_at_release", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rstmid_ready_after", {31'b0, req_ready}, 32'd1);
        checkOutput("rstmid_writes", 32'(wcnt - w0), 32'd2);
        checkOutput("rstmid_b5", {24'b0, mem[5]}, 32'hDD);
        checkOutput("rstmid_b6", {24'b0, mem[6]}, 32'hCC);
        checkOutput("rstmid_b7", {24'b0, mem[7]}, 32'h22);
        checkOutput("rstmid_b8", {24'b0, mem[8]}, 32'h11);
        applyStimulus(1'b0, 3'b010, 32'd4, 32'h0, lat, rdata, err, rdy);
        checkOutput("post_rst_lw4", rdata, 32'h22CCDD0F);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit directly upstream of dmem, between the datapath and data memory.
- Accepts one load/store request at a time over a valid/ready handshake and drives dmem's a/wd/we/mode pins; consumes dmem's combinational rd.
- Aligned accesses are a single dmem access. Misaligned halfword/word accesses are split into sequential byte accesses, reassembled and sign/zero-extended per RV32I funct3.

Parameters:
- ADDR_W, 32, width of request and memory address.
- LB_MODE, 3'b100, dmem mode code used for each split byte read (unsigned byte).
- SB_MODE, 3'b000, dmem mode code used for each split byte write.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (size/sign).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal funct3, or misaligned with trap enabled.
- mem_a  out  ADDR_W  to dmem a.
- mem_wd  out  32  to dmem wd.
- mem_we  out  1  to dmem we.
- mem_mode  out  3  to dmem mode.
- mem_rd  in  32  from dmem rd (combinational read).

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, including req_ready, mem_we, resp_valid and resp_err. Any in-flight access is aborted immediately. Bytes already written stay written.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid & req_ready. On acceptance addr, funct3, we and wdata are registered.
  - Illegal funct3 (loads: 011/110/111; stores: anything except 000/001/010) -> RESP with resp_err=1. No mem_we pulse.
  - Aligned -> ACCESS. Aligned means byte; half with addr[0]=0; word with addr[1:0]=0.
  - Otherwise -> SPLIT with n=2 (half) or 4 (word) and byte counter k=0.
- ACCESS (1 cycle): mem_a=addr, mem_mode=funct3, mem_we=we, mem_wd=wdata. mem_rd is captured at the end of the cycle. Next state RESP.
- SPLIT (n cycles): mem_a=addr+k, wrapping mod 2^ADDR_W.
  - Loads: mem_mode=LB_MODE; mem_rd[7:0] is latched into byte k of the assembly register.
  - Stores: mem_mode=SB_MODE, mem_we=1, mem_wd={24'b0, wdata byte k}.
  - k increments each cycle. After k=n-1 -> RESP.
- RESP (1 cycle): resp_valid=1.
  - Loads: LH sign-extends bit 15, LHU zero-extends, LW passes through; aligned loads take rdata as returned by dmem.
  - Stores: rdata=0.
  - Next state IDLE. req_ready=0 this cycle, so there is no back-to-back accept.
- Outside ACCESS/SPLIT: mem_we=0; mem_a, mem_wd and mem_mode are held at 0.
- Latency, accept edge to resp_valid: aligned 2 cycles; misaligned 1+n+... exactly n+1 cycles; illegal 1 cycle.
- req_* are ignored while not in IDLE.
- A reset deasserted mid-cycle resumes in IDLE on the next edge.

Optional Feature:
- DMEM_LSU_MISALIGN_TRAP_EN defined: a misaligned legal request goes IDLE->RESP with resp_err=1, rdata=0, and no memory access (for the trap path). SPLIT is not synthesized.
- Undefined: misaligned accesses are split as above and resp_err is set only for illegal funct3.

Test Plan:
- SW addr 4, wdata F00AA00F, funct3 010, then LW addr 4 -> one mem_we pulse with mem_mode=010; load resp_rdata=F00AA00F, resp_valid 2 cycles after accept.
- SW addr 5, wdata 11223344 -> mem_we on 4 consecutive cycles; (mem_a, mem_wd) = (5,44), (6,33), (7,22), (8,11); then LW addr 5 -> rdata 11223344 after 5 cycles.
- SB 80 at 11, SB FF at 12, then LH addr 11 -> rdata FFFFFF80 (sign); LHU addr 11 -> 0000FF80 (zero).
- LH at addr FFFFFFFF -> byte reads at FFFFFFFF then 00000000 (wrap).
- Load funct3 011 and store funct3 100 -> resp_err=1, rdata=0, mem_we never asserted.
- Assert reset=0 during SPLIT of SW at addr 5 after 2 bytes -> mem_we drops immediately; req_ready=0 until release, then 1; bytes 5,6 written, bytes 7,8 unchanged.
- With DMEM_LSU_MISALIGN_TRAP_EN, LW addr 6 -> resp_err=1 one cycle after accept, no dmem access.
